prog_timer: RTL and testbench
=============================

# prog_timer

Parametrised synchronous timer/frequency divider for the single-cycle SoC peripheral bus side. Replaces ripple-clocked toggle-flop division with a fully synchronous prescaler plus a loadable down-counter, giving a programmable divide ratio, one-shot or periodic mode, a sticky interrupt and a divided square-wave output. All flops run on the single system clock; no derived clocks are generated.

## Interface
- WIDTH, 16, main counter and reload width (2..32)
- PRESC_W, 8, prescaler width (1..16)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable; low freezes prescaler and counter, state kept
- load  input  1  one-cycle strobe: latch reload_val, restart, arm timer
- reload_val  input  WIDTH  reload/start value
- presc_div  input  PRESC_W  prescaler terminal value; tick period = presc_div+1 enabled cycles
- periodic  input  1  1 = auto-reload on expiry, 0 = one-shot
- irq_clr  input  1  clears irq
- count  output  WIDTH  current counter value
- tick  output  1  one-cycle prescaler tick pulse (registered)
- expire  output  1  one-cycle pulse on counter expiry (registered)
- irq  output  1  sticky interrupt, set by expiry
- div_out  output  1  toggles on every expiry (square wave)
- busy  output  1  high in RUN state

## Operation
- States: IDLE (reset; not armed), RUN, DONE (one-shot expired).
- IDLE -> RUN on load; RUN -> DONE on expiry with periodic=0; RUN stays RUN on expiry with periodic=1; DONE -> RUN on load. load in RUN restarts.
- load: count <= reload_val, reload register <= reload_val, prescaler <= 0; no tick/expire that cycle.
- Prescaler (RUN and en only): increments; when equal to presc_div it returns to 0 and tick pulses next cycle. presc_div=0 -> tick on every enabled cycle.
- Counter, on each prescaler terminal in RUN: if count != 0, count <= count-1; if count == 0, expiry: expire pulses, irq <= 1, div_out toggles, count <= stored reload (periodic) or stays 0 (one-shot, go DONE).
- Expiry period = (reload+1)*(presc_div+1) enabled cycles. reload=0 periodic -> expiry on every tick.
- Unsigned arithmetic, no wrap below 0; counter never decrements past 0.
- irq cleared by irq_clr; expiry in the same cycle as irq_clr wins (irq stays 1).
- load and a terminal prescaler count in the same cycle: load wins, no expiry.
- presc_div changed mid-run: takes effect immediately; if prescaler already > new presc_div it counts up, wraps at 2^PRESC_W, then matches.
- en low: prescaler, counter, div_out frozen; tick/expire 0; load still honoured.

## Timing
- Reset (async assert, sync release): count=0, prescaler=0, tick=0, expire=0, irq=0, div_out=0, busy=0, state IDLE, reload register=0.
- tick, expire, irq, div_out, count all registered; expire and irq update on the same edge as the count reload.
- First expiry after load: (reload_val+1)*(presc_div+1) enabled cycles after the load edge.
- irq_clr effective on next edge; reset mid-run returns to IDLE immediately, no expire pulse.

## Configuration
- TIMER_PWM_EN defined: adds input cmp_val[WIDTH-1:0] and output pwm_out; pwm_out registered, = 1 while RUN and count < cmp_val, else 0; reset 0; cmp_val=0 gives constant 0, cmp_val > reload gives constant 1 while RUN.
- TIMER_PWM_EN undefined: ports and logic absent; all other behaviour identical.

## Test plan
- Reset mid-run with count=5 -> all outputs 0, busy=0, irq=0 asynchronously; no expire after release until load.
- WIDTH=16, presc_div=0, reload=3, periodic=1, en=1, load -> expire every 4 cycles, div_out period 8 cycles, irq set at first expiry.
- presc_div=2, reload=1, periodic=0 -> single expire 6 cycles after load, state DONE, count holds 0, busy=0; second load re-arms.
- irq_clr asserted on same cycle as expiry -> irq remains 1; irq_clr one cycle later -> irq 0.
- en low for 10 cycles mid-count at count=7 -> count and div_out frozen, no tick; resumes at 7 when en returns.
- TIMER_PWM_EN, reload=9, presc_div=0, cmp_val=3 -> pwm_out high 3 of every 10 cycles.

Source files
------------

// File: rtl/prog_timer_if.sv
// Bus bundle between prog_timer and its controller.
// The PWM compare/output pair exists only when TIMER_PWM_EN is defined.
interface prog_timer_if #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
);
  logic               en;
  logic               load;
  logic [WIDTH-1:0]   reload_val;
  logic [PRESC_W-1:0] presc_div;
  logic               periodic;
  logic               irq_clr;
  logic [WIDTH-1:0]   count;
  logic               tick;
  logic               expire;
  logic               irq;
  logic               div_out;
  logic               busy;
`ifdef TIMER_PWM_EN
  logic [WIDTH-1:0]   cmp_val;
  logic               pwm_out;
`endif

  modport master (
    output en, load, reload_val, presc_div, periodic, irq_clr,
`ifdef TIMER_PWM_EN
    output cmp_val,
    input  pwm_out,
`endif
    input  count, tick, expire, irq, div_out, busy
  );

  modport slave (
    input  en, load, reload_val, presc_div, periodic, irq_clr,
`ifdef TIMER_PWM_EN
    input  cmp_val,
    output pwm_out,
`endif
    output count, tick, expire, irq, div_out, busy
  );
endinterface

// File: rtl/prog_timer.sv
// Synchronous prescaler + loadable down-counter timer with sticky irq and divided output.
// Optional PWM compare output is built when TIMER_PWM_EN is defined.
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | after reset, timer not armed, count held at 0
// RUN   | armed, prescaler/counter advance while en is high
// DONE  | one-shot expired, count held at 0 until next load
module prog_timer #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  prog_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   reload_q;
  logic [PRESC_W-1:0] presc_q;
  logic               tick_q;
  logic               expire_q;
  logic               irq_q;
  logic               div_q;
  logic               busy_q;

  logic run_en;
  logic presc_term;
  logic expiry;

  // load has priority over any terminal count in the same cycle
  always_comb begin
    run_en     = (state_q == RUN) && bus.en && !bus.load;
    presc_term = run_en && (presc_q == bus.presc_div);
    expiry     = presc_term && (count_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      expire_q <= 1'b0;
      div_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      tick_q   <= 1'b0;
      expire_q <= 1'b0;
      if (bus.load) begin
        count_q  <= bus.reload_val;
        reload_q <= bus.reload_val;
        presc_q  <= '0;
        state_q  <= RUN;
        busy_q   <= 1'b1;
      end else if (run_en) begin
        if (presc_term) begin
          presc_q <= '0;
          tick_q  <= 1'b1;
          if (count_q != '0) begin
            count_q <= count_q - 1'b1;
          end else begin
            expire_q <= 1'b1;
            div_q    <= ~div_q;
            if (bus.periodic) begin
              count_q <= reload_q;
            end else begin
              count_q <= '0;
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
        end else begin
          // a prescaler above a freshly lowered presc_div wraps through 2^PRESC_W
          presc_q <= presc_q + 1'b1;
        end
      end
    end
  end

  // expiry beats a simultaneous clear so no event is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      irq_q <= 1'b0;
    else if (expiry)
      irq_q <= 1'b1;
    else if (bus.irq_clr)
      irq_q <= 1'b0;
  end

  assign bus.count   = count_q;
  assign bus.tick    = tick_q;
  assign bus.expire  = expire_q;
  assign bus.irq     = irq_q;
  assign bus.div_out = div_q;
  assign bus.busy    = busy_q;

`ifdef TIMER_PWM_EN
  logic pwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pwm_q <= 1'b0;
    else
      pwm_q <= (state_q == RUN) && (count_q < bus.cmp_val);
  end

  assign bus.pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: directed scenarios plus a randomized run
// compared against an arithmetic model of elapsed enabled cycles.
module tb_prog_timer;
  localparam int WIDTH   = 16;
  localparam int PRESC_W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  prog_timer_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

  prog_timer #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: derives state from enabled cycles elapsed since load
  bit m_run;
  int m_rel, m_p, m_n, m_cnt;
  bit m_tick, m_exp, m_irq, m_div;

  task automatic model_reset();
    m_run = 0; m_rel = 0; m_p = 0; m_n = 0; m_cnt = 0;
    m_tick = 0; m_exp = 0; m_irq = 0; m_div = 0;
  endtask

  task automatic model_edge();
    int t;
    m_tick = 0;
    m_exp  = 0;
    if (bus.load) begin
      m_run = 1; m_rel = int'(bus.reload_val); m_p = int'(bus.presc_div);
      m_n = 0; m_cnt = m_rel;
    end else if (m_run && bus.en) begin
      m_n++;
      if (m_n % (m_p + 1) == 0) begin
        t = m_n / (m_p + 1);
        m_tick = 1;
        if (t % (m_rel + 1) == 0) begin
          m_exp = 1;
          m_div = !m_div;
          if (!bus.periodic) begin
            m_run = 0;
            m_cnt = 0;
          end else begin
            m_cnt = m_rel;
          end
        end else begin
          m_cnt = m_rel - (t % (m_rel + 1));
        end
      end
    end
    if (m_exp) m_irq = 1;
    else if (bus.irq_clr) m_irq = 0;
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    bus.en = 1'b1; bus.load = 1'b0; bus.reload_val = '0; bus.presc_div = '0;
    bus.periodic = 1'b1; bus.irq_clr = 1'b0;
`ifdef TIMER_PWM_EN
    bus.cmp_val = '0;
`endif
  endtask

  task automatic do_load(input int rel, input int pd, input bit per);
    bus.reload_val = rel[WIDTH-1:0];
    bus.presc_div  = pd[PRESC_W-1:0];
    bus.periodic   = per;
    bus.load       = 1'b1;
    clk_step();
    bus.load       = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    #2 rst = 1'b1;
    repeat (2) clk_step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bit seen_exp, seen_busy;
    apply_reset();
    n_checks++; if (bus.count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_checks++; if ({bus.tick, bus.expire, bus.irq, bus.div_out, bus.busy} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=00000", {bus.tick, bus.expire, bus.irq, bus.div_out, bus.busy}); end
    do_load(1, 0, 1'b1);
    repeat (3) clk_step();
    n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got=%b exp=1", bus.irq); end
    do_load(20, 0, 1'b1);
    repeat (15) clk_step();
    n_checks++; if (bus.count !== 16'd5) begin n_fail++; $display("FAIL pre_reset_count got=%0d exp=5", bus.count); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.count !== 16'd0) begin n_fail++; $display("FAIL async_reset_count got=%0d exp=0", bus.count); end
    n_checks++; if ({bus.tick, bus.expire, bus.irq, bus.div_out, bus.busy} !== 5'b0) begin n_fail++; $display("FAIL async_reset_flags got=%b exp=00000", {bus.tick, bus.expire, bus.irq, bus.div_out, bus.busy}); end
    clk_step();
    rst = 1'b0;
    seen_exp = 0; seen_busy = 0;
    for (int i = 0; i < 30; i++) begin
      clk_step();
      if (bus.expire) seen_exp = 1;
      if (bus.busy) seen_busy = 1;
    end
    n_checks++; if (seen_exp !== 1'b0) begin n_fail++; $display("FAIL post_reset_expire got=%b exp=0", seen_exp); end
    n_checks++; if (seen_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b exp=0", seen_busy); end
  endtask

  task automatic test_periodic();
    logic [15:0] ecnt;
    apply_reset();
    do_load(3, 0, 1'b1);
    for (int i = 1; i <= 24; i++) begin
      clk_step();
      ecnt = 16'(3 - (i % 4));
      n_checks++; if (bus.expire !== (i % 4 == 0)) begin n_fail++; $display("FAIL periodic_expire i=%0d got=%b exp=%b", i, bus.expire, (i % 4 == 0)); end
      n_checks++; if (bus.div_out !== ((i / 4) % 2 == 1)) begin n_fail++; $display("FAIL periodic_div i=%0d got=%b exp=%b", i, bus.div_out, ((i / 4) % 2 == 1)); end
      n_checks++; if (bus.irq !== (i >= 4)) begin n_fail++; $display("FAIL periodic_irq i=%0d got=%b exp=%b", i, bus.irq, (i >= 4)); end
      n_checks++; if (bus.count !== ecnt) begin n_fail++; $display("FAIL periodic_count i=%0d got=%0d exp=%0d", i, bus.count, ecnt); end
    end
  endtask

  task automatic test_oneshot();
    for (int pass = 0; pass < 2; pass++) begin
      do_load(1, 2, 1'b0);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL oneshot_armed pass=%0d got=%b exp=1", pass, bus.busy); end
      for (int i = 1; i <= 12; i++) begin
        clk_step();
        n_checks++; if (bus.expire !== (i == 6)) begin n_fail++; $display("FAIL oneshot_expire i=%0d got=%b exp=%b", i, bus.expire, (i == 6)); end
        n_checks++; if (bus.tick !== (i % 3 == 0 && i <= 6)) begin n_fail++; $display("FAIL oneshot_tick i=%0d got=%b exp=%b", i, bus.tick, (i % 3 == 0 && i <= 6)); end
        n_checks++; if (bus.busy !== (i < 6)) begin n_fail++; $display("FAIL oneshot_busy i=%0d got=%b exp=%b", i, bus.busy, (i < 6)); end
        n_checks++; if (bus.count !== ((i < 3) ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL oneshot_count i=%0d got=%0d exp=%0d", i, bus.count, (i < 3) ? 1 : 0); end
      end
    end
  endtask

  task automatic test_irq_clr();
    bus.irq_clr = 1'b1;
    do_load(2, 0, 1'b1);
    bus.irq_clr = 1'b0;
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr_basic got=%b exp=0", bus.irq); end
    repeat (2) clk_step();
    bus.irq_clr = 1'b1;
    clk_step();
    n_checks++; if (bus.expire !== 1'b1) begin n_fail++; $display("FAIL irq_clr_expire got=%b exp=1", bus.expire); end
    n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_clr_same_cycle got=%b exp=1", bus.irq); end
    clk_step();
    bus.irq_clr = 1'b0;
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr_next got=%b exp=0", bus.irq); end
    repeat (2) clk_step();
    n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_reset_by_expiry got=%b exp=1", bus.irq); end
  endtask

  task automatic test_en_freeze();
    logic div_hold;
    do_load(20, 1, 1'b1);
    repeat (27) clk_step();
    n_checks++; if (bus.count !== 16'd7) begin n_fail++; $display("FAIL freeze_start got=%0d exp=7", bus.count); end
    div_hold = bus.div_out;
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      n_checks++; if (bus.count !== 16'd7) begin n_fail++; $display("FAIL freeze_count i=%0d got=%0d exp=7", i, bus.count); end
      n_checks++; if (bus.tick !== 1'b0 || bus.div_out !== div_hold) begin n_fail++; $display("FAIL freeze_tick_div i=%0d got=%b%b exp=0%b", i, bus.tick, bus.div_out, div_hold); end
    end
    bus.en = 1'b1;
    clk_step();
    n_checks++; if (bus.count !== 16'd6 || bus.tick !== 1'b1) begin n_fail++; $display("FAIL resume got=%0d/%b exp=6/1", bus.count, bus.tick); end
    bus.en = 1'b0;
    do_load(4, 1, 1'b1);
    clk_step();
    n_checks++; if (bus.count !== 16'd4 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL load_while_disabled got=%0d/%b exp=4/1", bus.count, bus.busy); end
    bus.en = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_load(0, 0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      clk_step();
      n_checks++; if (bus.expire !== 1'b1 || bus.count !== 16'd0) begin n_fail++; $display("FAIL reload0_expire i=%0d got=%b/%0d exp=1/0", i, bus.expire, bus.count); end
    end
    do_load(7, 0, 1'b1);
    n_checks++; if (bus.expire !== 1'b0 || bus.tick !== 1'b0 || bus.count !== 16'd7) begin n_fail++; $display("FAIL load_beats_term got=%b%b/%0d exp=00/7", bus.expire, bus.tick, bus.count); end
  endtask

  task automatic test_presc_change();
    bit early;
    do_load(10, 5, 1'b1);
    repeat (4) clk_step();
    bus.presc_div = 8'd1;
    early = 0;
    for (int k = 1; k <= 253; k++) begin
      clk_step();
      if (bus.count !== 16'd10 || bus.tick !== 1'b0) early = 1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL presc_wrap_early got=%b exp=0", early); end
    clk_step();
    n_checks++; if (bus.count !== 16'd9 || bus.tick !== 1'b1) begin n_fail++; $display("FAIL presc_wrap_match got=%0d/%b exp=9/1", bus.count, bus.tick); end
  endtask

`ifdef TIMER_PWM_EN
  task automatic test_pwm();
    int highs;
    bus.cmp_val = 16'd3;
    do_load(9, 0, 1'b1);
    repeat (12) clk_step();
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      if (bus.pwm_out === 1'b1) highs++;
    end
    n_checks++; if (highs != 6) begin n_fail++; $display("FAIL pwm_duty got=%0d exp=6", highs); end
    bus.cmp_val = 16'd0;
  endtask
`endif

  task automatic test_random();
    logic [15:0] ecnt;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 0 || $urandom_range(99) < 4) begin
        bus.load      = 1'b1;
        bus.presc_div = 8'($urandom_range(3));
        bus.periodic  = ($urandom_range(2) != 0);
      end else begin
        bus.load = 1'b0;
      end
      bus.reload_val = 16'($urandom_range(5));
      bus.en         = ($urandom_range(99) < 85);
      bus.irq_clr    = ($urandom_range(99) < 10);
      clk_step();
      ecnt = m_cnt[15:0];
      n_checks++; if (bus.count !== ecnt) begin n_fail++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, bus.count, ecnt); end
      n_checks++; if (bus.tick !== m_tick) begin n_fail++; $display("FAIL rand_tick i=%0d got=%b exp=%b", i, bus.tick, m_tick); end
      n_checks++; if (bus.expire !== m_exp) begin n_fail++; $display("FAIL rand_expire i=%0d got=%b exp=%b", i, bus.expire, m_exp); end
      n_checks++; if (bus.irq !== m_irq) begin n_fail++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, bus.irq, m_irq); end
      n_checks++; if (bus.div_out !== m_div) begin n_fail++; $display("FAIL rand_div i=%0d got=%b exp=%b", i, bus.div_out, m_div); end
      n_checks++; if (bus.busy !== m_run) begin n_fail++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, bus.busy, m_run); end
    end
    drive_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive_idle();
    model_reset();
    test_reset();
    test_periodic();
    test_oneshot();
    test_irq_clr();
    test_en_freeze();
    test_back_to_back();
    test_presc_change();
`ifdef TIMER_PWM_EN
    test_pwm();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
